// File: rtl/linebuffer_2x2.sv
// Two-row line buffer: pairs each accepted pixel with the same-column pixel of
// the previous line, for downstream 2x2 windowing/pooling.
// Optional feature: define LB2X2_FRAME_WRAP_EN to add a row counter that
// restarts the line history at each frame boundary (IMG_HEIGHT lines/frame).
module linebuffer_2x2 #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned IMG_WIDTH  = 480,
   parameter int unsigned IMG_HEIGHT = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout_r0,
   output logic [DATA_WIDTH-1:0] dout_r1,
   output logic                  mat_flag
);

   localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

   // Reject unusable geometry at elaboration time
   if (IMG_WIDTH < 2 || IMG_HEIGHT < 1) begin : g_bad_param
      $error("linebuffer_2x2: IMG_WIDTH must be >= 2 and IMG_HEIGHT >= 1");
   end

   logic [DATA_WIDTH-1:0] mem_q [IMG_WIDTH];
   logic [COL_W-1:0]      col_q, col_d;
   logic                  line_full_q, line_full_d;
   logic [DATA_WIDTH-1:0] dout_r0_q, dout_r1_q;
   logic                  mat_flag_q;
   logic                  wrap_c;

`ifdef LB2X2_FRAME_WRAP_EN
   localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   logic [ROW_W-1:0] row_q, row_d;
`endif

   // Line memory: unreset, written with the incoming pixel at the current column
   always_ff @(posedge clk) begin
      if (valid_in) begin
         mem_q[col_q] <= din;
      end
   end

   // Next-state for column / row position and the line-full flag
   always_comb begin
      col_d       = col_q;
      line_full_d = line_full_q;
      wrap_c      = valid_in && (col_q == COL_LAST);
`ifdef LB2X2_FRAME_WRAP_EN
      row_d       = row_q;
`endif
      if (valid_in) begin
         col_d = wrap_c ? '0 : col_q + COL_W'(1);
      end
      if (wrap_c) begin
         line_full_d = 1'b1;
`ifdef LB2X2_FRAME_WRAP_EN
         // Last pixel of the frame: restart so no pair spans two frames
         if (row_q == ROW_LAST) begin
            row_d       = '0;
            line_full_d = 1'b0;
         end else begin
            row_d = row_q + ROW_W'(1);
         end
`endif
      end
   end

   // State and output registers; memory read here sees the pre-write value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         line_full_q <= 1'b0;
         dout_r0_q   <= '0;
         dout_r1_q   <= '0;
         mat_flag_q  <= 1'b0;
`ifdef LB2X2_FRAME_WRAP_EN
         row_q       <= '0;
`endif
      end else begin
         col_q       <= col_d;
         line_full_q <= line_full_d;
         mat_flag_q  <= valid_in & line_full_q;
`ifdef LB2X2_FRAME_WRAP_EN
         row_q       <= row_d;
`endif
         if (valid_in) begin
            dout_r0_q <= line_full_q ? mem_q[col_q] : '0;
            dout_r1_q <= din;
         end
      end
   end

   assign dout_r0  = dout_r0_q;
   assign dout_r1  = dout_r1_q;
   assign mat_flag = mat_flag_q;

endmodule

// File: tb/tb_linebuffer_2x2.sv
// Bench for linebuffer_2x2 (IMG_WIDTH=4, IMG_HEIGHT=2). The reference keeps the
// list of pixels accepted since reset and pairs pixel k with pixel k-IMG_WIDTH.
module tb_linebuffer_2x2;

   localparam int unsigned DW = 8;
   localparam int unsigned W  = 4;
   localparam int unsigned H  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          valid_in = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout_r0, dout_r1;
   logic          mat_flag;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [DW-1:0] hist[$];
   logic [DW-1:0] exp_r0 = '0;
   logic [DW-1:0] exp_r1 = '0;
   logic          exp_mat = 1'b0;

   linebuffer_2x2 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_in (valid_in),
      .din      (din),
      .dout_r0  (dout_r0),
      .dout_r1  (dout_r1),
      .mat_flag (mat_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".r0"},  dout_r0,          exp_r0);
      check({tag, ".r1"},  dout_r1,          exp_r1);
      check({tag, ".mat"}, DW'(mat_flag),    DW'(exp_mat));
   endtask

   // Reference: pair with the pixel one line earlier, unless it lies in a previous frame
   task automatic model_accept(input logic [DW-1:0] d);
      int unsigned k;
      int unsigned pos;
      k   = hist.size();
`ifdef LB2X2_FRAME_WRAP_EN
      pos = k % (W * H);
`else
      pos = k;
`endif
      if (pos >= W) begin
         exp_r0  = hist[k - W];
         exp_mat = 1'b1;
      end else begin
         exp_r0  = '0;
         exp_mat = 1'b0;
      end
      exp_r1 = d;
      hist.push_back(d);
   endtask

   task automatic step(input logic v, input logic [DW-1:0] d, input string tag);
      @(negedge clk);
      valid_in = v;
      din      = v ? d : DW'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      if (v) model_accept(d);
      else   exp_mat = 1'b0;
      check_all(tag);
   endtask

   // Asynchronous reset between edges; outputs must clear without a clock
   task automatic do_reset(input string tag);
      @(negedge clk);
      valid_in = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      hist.delete();
      exp_r0 = '0; exp_r1 = '0; exp_mat = 1'b0;
      check_all(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // 1: reset held, idle for 10 cycles
      rst_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check_all("reset_idle");
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, '0, "idle_after_reset");

      // 2: continuous pixels 1..12
      for (int i = 1; i <= 12; i++) step(1'b1, DW'(i), "cont");

      // 3: same stream with a 3-cycle gap after pixel 6
      do_reset("rst_before_gap");
      for (int i = 1; i <= 6; i++) step(1'b1, DW'(i), "gap_pre");
      for (int i = 0; i < 3; i++)  step(1'b0, '0, "gap_hold");
      for (int i = 7; i <= 12; i++) step(1'b1, DW'(i), "gap_post");

      // 4: reset after pixel 7, restart 1..8
      do_reset("rst_before_mid");
      for (int i = 1; i <= 7; i++) step(1'b1, DW'(i), "mid_pre");
      do_reset("rst_mid");
      for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), "mid_post");

      // 5/6: 16 pixels, frame boundary behaviour depends on build
      do_reset("rst_frame");
      for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), "frame16");

      // Random pixels with random gaps and occasional resets
      do_reset("rst_rand");
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset("rst_rand_mid");
         step(($urandom_range(0, 3) != 0), DW'($urandom_range(0, 255)), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
